// File: rtl/mem_if_arbiter.sv
// Two-into-one arbiter sharing the core memory bus between imem (fetch) and dmem (load/store).
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants under contention; default is dmem priority.
module mem_if_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              f_clk,
   input  logic              g_resetn,

   input  logic              imem_req_i,
   input  logic [ADDR_W-1:0] imem_addr_i,
   input  logic              imem_wen_i,
   input  logic [STRB_W-1:0] imem_strb_i,
   input  logic [DATA_W-1:0] imem_wdata_i,
   output logic              imem_gnt_o,
   output logic              imem_err_o,
   output logic [DATA_W-1:0] imem_rdata_o,

   input  logic              dmem_req_i,
   input  logic [ADDR_W-1:0] dmem_addr_i,
   input  logic              dmem_wen_i,
   input  logic [STRB_W-1:0] dmem_strb_i,
   input  logic [DATA_W-1:0] dmem_wdata_i,
   output logic              dmem_gnt_o,
   output logic              dmem_err_o,
   output logic [DATA_W-1:0] dmem_rdata_o,

   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wen_o,
   output logic [STRB_W-1:0] mem_strb_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_err_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t state_q, state_d;
   logic   rsp_valid_q, rsp_valid_d;
   logic   rsp_owner_q, rsp_owner_d;
   logic   last_grant_q, last_grant_d;

   logic   sel_s;
   logic   req_s;
   logic   gnt_s;
   logic   contend_pick_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign contend_pick_s = ~last_grant_q;
`else
   assign contend_pick_s = OWN_D;
`endif

   // Owner selection, downstream request and next state
   always_comb begin
      state_d = state_q;
      sel_s   = OWN_I;
      req_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (imem_req_i && dmem_req_i) begin
               sel_s = contend_pick_s;
            end else if (dmem_req_i) begin
               sel_s = OWN_D;
            end else begin
               sel_s = OWN_I;
            end
            req_s = imem_req_i | dmem_req_i;
            // An unaccepted request locks the bus to its owner until mem_gnt.
            if (req_s && !mem_gnt_i) begin
               state_d = (sel_s == OWN_D) ? HOLD_D : HOLD_I;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD_I: begin
            sel_s   = OWN_I;
            req_s   = imem_req_i;
            state_d = mem_gnt_i ? IDLE : HOLD_I;
         end
         HOLD_D: begin
            sel_s   = OWN_D;
            req_s   = dmem_req_i;
            state_d = mem_gnt_i ? IDLE : HOLD_D;
         end
         default: begin
            sel_s   = OWN_I;
            req_s   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign mem_req_o   = req_s & g_resetn;
   assign mem_addr_o  = (sel_s == OWN_D) ? dmem_addr_i  : imem_addr_i;
   assign mem_wen_o   = (sel_s == OWN_D) ? dmem_wen_i   : imem_wen_i;
   assign mem_strb_o  = (sel_s == OWN_D) ? dmem_strb_i  : imem_strb_i;
   assign mem_wdata_o = (sel_s == OWN_D) ? dmem_wdata_i : imem_wdata_i;

   assign gnt_s      = mem_gnt_i & mem_req_o;
   assign imem_gnt_o = gnt_s & (sel_s == OWN_I);
   assign dmem_gnt_o = gnt_s & (sel_s == OWN_D);

   // Response bookkeeping: remember who owns the transaction answered next cycle
   always_comb begin
      rsp_valid_d  = gnt_s;
      rsp_owner_d  = rsp_owner_q;
      last_grant_d = last_grant_q;
      if (gnt_s) begin
         rsp_owner_d  = sel_s;
         last_grant_d = sel_s;
      end else begin
         rsp_owner_d  = rsp_owner_q;
         last_grant_d = last_grant_q;
      end
   end

   assign imem_err_o   = mem_err_i & rsp_valid_q & (rsp_owner_q == OWN_I) & g_resetn;
   assign dmem_err_o   = mem_err_i & rsp_valid_q & (rsp_owner_q == OWN_D) & g_resetn;
   assign imem_rdata_o = mem_rdata_i;
   assign dmem_rdata_o = mem_rdata_i;

   // State and response-tracking registers with synchronous reset
   always_ff @(posedge f_clk) begin
      if (!g_resetn) begin
         state_q      <= IDLE;
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= OWN_I;
         last_grant_q <= OWN_I;
      end else begin
         state_q      <= state_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_owner_q  <= rsp_owner_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Scoreboard bench for mem_if_arbiter: stimulus queues expected grants/responses, a monitor checks them.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to check the alternating-grant mode.
module tb_mem_if_arbiter;

   logic        f_clk = 1'b0;
   logic        g_resetn;
   logic        imem_req_i, imem_wen_i, dmem_req_i, dmem_wen_i;
   logic [63:0] imem_addr_i, imem_wdata_i, dmem_addr_i, dmem_wdata_i;
   logic [7:0]  imem_strb_i, dmem_strb_i;
   logic        imem_gnt_o, imem_err_o, dmem_gnt_o, dmem_err_o;
   logic [63:0] imem_rdata_o, dmem_rdata_o;
   logic        mem_req_o, mem_wen_o;
   logic [63:0] mem_addr_o, mem_wdata_o;
   logic [7:0]  mem_strb_o;
   logic        mem_gnt_i, mem_err_i;
   logic [63:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        who;
      logic [63:0] addr;
      logic        wen;
      logic [7:0]  strb;
   } gnt_t;

   typedef struct {
      logic        ierr;
      logic        derr;
      logic [63:0] rdata;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];

   always #5 f_clk = ~f_clk;

   mem_if_arbiter dut (
      .f_clk(f_clk), .g_resetn(g_resetn),
      .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_wen_i(imem_wen_i),
      .imem_strb_i(imem_strb_i), .imem_wdata_i(imem_wdata_i),
      .imem_gnt_o(imem_gnt_o), .imem_err_o(imem_err_o), .imem_rdata_o(imem_rdata_o),
      .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_wen_i(dmem_wen_i),
      .dmem_strb_i(dmem_strb_i), .dmem_wdata_i(dmem_wdata_i),
      .dmem_gnt_o(dmem_gnt_o), .dmem_err_o(dmem_err_o), .dmem_rdata_o(dmem_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
      .mem_strb_o(mem_strb_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s @%0t", nm, $time);
   endtask

   task automatic cyc();
      @(posedge f_clk);
      #1;
   endtask

   task automatic expect_txn(input logic who, input logic [63:0] a, input logic w,
                             input logic [7:0] s, input logic ie, input logic de,
                             input logic [63:0] rd);
      gnt_t g;
      rsp_t r;
      g.who = who; g.addr = a; g.wen = w; g.strb = s;
      r.ierr = ie; r.derr = de; r.rdata = rd;
      gq.push_back(g);
      rq.push_back(r);
   endtask

   // Monitor: pops a grant on every x_gnt and a response in the following cycle
   initial begin
      logic due;
      gnt_t g;
      rsp_t r;
      due = 1'b0;
      forever begin
         @(negedge f_clk);
         if (!g_resetn) begin
            due = 1'b0;
         end else begin
            if (due) begin
               if (rq.size() == 0) begin
                  fail("unexpected_response");
               end else begin
                  r = rq.pop_front();
                  chk("imem_err", {63'd0, imem_err_o}, {63'd0, r.ierr});
                  chk("dmem_err", {63'd0, dmem_err_o}, {63'd0, r.derr});
                  chk("imem_rdata", imem_rdata_o, r.rdata);
                  chk("dmem_rdata", dmem_rdata_o, r.rdata);
               end
            end else if (mem_err_i) begin
               chk("imem_err_unowned", {63'd0, imem_err_o}, 64'd0);
               chk("dmem_err_unowned", {63'd0, dmem_err_o}, 64'd0);
            end
            if (imem_gnt_o || dmem_gnt_o) begin
               due = 1'b1;
               if (gq.size() == 0) begin
                  fail("unexpected_gnt");
               end else begin
                  g = gq.pop_front();
                  chk("gnt_owner", {62'd0, dmem_gnt_o, imem_gnt_o}, g.who ? 64'd2 : 64'd1);
                  chk("gnt_addr", mem_addr_o, g.addr);
                  chk("gnt_wen_strb", {55'd0, mem_wen_o, mem_strb_o}, {55'd0, g.wen, g.strb});
               end
            end else begin
               due = 1'b0;
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      logic exp_who;
      g_resetn = 1'b0;
      imem_req_i = 1'b1; imem_addr_i = 64'd0; imem_wen_i = 1'b0; imem_strb_i = 8'd0; imem_wdata_i = 64'd0;
      dmem_req_i = 1'b1; dmem_addr_i = 64'd0; dmem_wen_i = 1'b0; dmem_strb_i = 8'd0; dmem_wdata_i = 64'd0;
      mem_gnt_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 64'd0;

      // Reset: all request/grant/error outputs gated off despite active inputs
      cyc();
      @(negedge f_clk);
      chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
      chk("rst_gnts", {62'd0, dmem_gnt_o, imem_gnt_o}, 64'd0);
      chk("rst_errs", {62'd0, dmem_err_o, imem_err_o}, 64'd0);
      cyc();
      imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_err_i = 1'b0;
      cyc();
      g_resetn = 1'b1;
      cyc();

      // Single imem read granted immediately
      imem_req_i = 1'b1; imem_addr_i = 64'h1000; mem_gnt_i = 1'b1;
      expect_txn(1'b0, 64'h1000, 1'b0, 8'h00, 1'b0, 1'b0, 64'hDEAD);
      cyc();
      imem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 64'hDEAD;
      cyc();
      mem_rdata_i = 64'd0;
      cyc();

      // dmem write stalled 3 cycles, imem arrives alongside and must wait
      for (int k = 0; k < 4; k++) begin
         dmem_req_i = 1'b1; dmem_addr_i = 64'h2000; dmem_wen_i = 1'b1;
         dmem_strb_i = 8'hFF; dmem_wdata_i = 64'hCAFE_F00D_1234_5678;
         imem_req_i = 1'b1; imem_addr_i = 64'h3000;
         mem_gnt_i = (k == 3);
         if (k == 3) expect_txn(1'b1, 64'h2000, 1'b1, 8'hFF, 1'b0, 1'b0, 64'h5555);
         @(negedge f_clk);
         chk("hold_d_req", {63'd0, mem_req_o}, 64'd1);
         chk("hold_d_addr", mem_addr_o, 64'h2000);
         chk("hold_d_wdata", mem_wdata_o, 64'hCAFE_F00D_1234_5678);
         chk("hold_d_gnt", {62'd0, dmem_gnt_o, imem_gnt_o}, (k == 3) ? 64'd2 : 64'd0);
         cyc();
      end
      dmem_req_i = 1'b0; dmem_wen_i = 1'b0; dmem_strb_i = 8'd0;
      mem_gnt_i = 1'b1; mem_rdata_i = 64'h5555;
      expect_txn(1'b0, 64'h3000, 1'b0, 8'h00, 1'b0, 1'b0, 64'hBEEF);
      cyc();
      imem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 64'hBEEF;
      cyc();
      mem_rdata_i = 64'd0;

      // Fresh reset so last_grant starts at I, then sustained contention
      g_resetn = 1'b0;
      cyc();
      g_resetn = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) begin
         imem_req_i = 1'b1; imem_addr_i = 64'h4000;
         dmem_req_i = 1'b1; dmem_addr_i = 64'h5000;
         mem_gnt_i = 1'b1;
         mem_rdata_i = 64'hA0 + 64'(k) - 64'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_who = (k % 2 == 0) ? 1'b1 : 1'b0;
`else
         exp_who = 1'b1;
`endif
         expect_txn(exp_who, exp_who ? 64'h5000 : 64'h4000, 1'b0, 8'h00, 1'b0, 1'b0, 64'hA0 + 64'(k));
         cyc();
      end
      imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 64'hA3;
      cyc();

      // dmem response error routed to dmem only; unowned mem_err ignored
      dmem_req_i = 1'b1; dmem_addr_i = 64'h6000; mem_gnt_i = 1'b1;
      expect_txn(1'b1, 64'h6000, 1'b0, 8'h00, 1'b0, 1'b1, 64'h77);
      cyc();
      dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_err_i = 1'b1; mem_rdata_i = 64'h77;
      cyc();
      mem_rdata_i = 64'd0;
      cyc();
      mem_err_i = 1'b0;
      cyc();

      // Reset during HOLD_I: bus released, then the pending dmem wins at once
      imem_req_i = 1'b1; imem_addr_i = 64'h8000;
      @(negedge f_clk);
      chk("hold_i_addr0", mem_addr_o, 64'h8000);
      cyc();
      dmem_req_i = 1'b1; dmem_addr_i = 64'h9000; dmem_wen_i = 1'b1; dmem_strb_i = 8'h0F;
      @(negedge f_clk);
      chk("hold_i_ignores_d", mem_addr_o, 64'h8000);
      cyc();
      g_resetn = 1'b0;
      @(negedge f_clk);
      chk("rst_in_hold_req", {63'd0, mem_req_o}, 64'd0);
      cyc();
      g_resetn = 1'b1; mem_gnt_i = 1'b1;
      expect_txn(1'b1, 64'h9000, 1'b1, 8'h0F, 1'b0, 1'b0, 64'h91);
      cyc();
      dmem_req_i = 1'b0; dmem_wen_i = 1'b0; dmem_strb_i = 8'd0; mem_rdata_i = 64'h91;
      expect_txn(1'b0, 64'h8000, 1'b0, 8'h00, 1'b0, 1'b0, 64'h81);
      cyc();
      imem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 64'h81;
      cyc();
      mem_rdata_i = 64'd0;
      cyc();
      cyc();

      chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_if_arbiter.md
# mem_if_arbiter

Two-into-one arbiter sharing the core's single memory bus between the instruction-fetch port (imem) and the load/store port (dmem). It sits between the core pipeline and the external memory interface. It preserves the bus request-stability rule on the downstream port: once mem_req is raised, mem_req/addr/wen/strb/wdata stay stable until mem_gnt. It routes each one-cycle-delayed response error back to the requester that owned the granted transaction.

## Interface
- ADDR_W, 64, memory address width
- DATA_W, 64, memory data width; STRB_W = DATA_W/8
- f_clk  in  1  global clock
- g_resetn  in  1  global reset, synchronous, active-low
- imem_req / dmem_req  in  1  requester request; held stable until its gnt
- imem_addr / dmem_addr  in  ADDR_W  request address
- imem_wen / dmem_wen  in  1  write enable (imem_wen is always 0 by construction)
- imem_strb / dmem_strb  in  STRB_W  write strobe
- imem_wdata / dmem_wdata  in  DATA_W  write data
- imem_gnt / dmem_gnt  out  1  request accepted
- imem_err / dmem_err  out  1  response error, cycle after gnt
- imem_rdata / dmem_rdata  out  DATA_W  read data, cycle after gnt (broadcast of mem_rdata)
- mem_req, mem_addr, mem_wen, mem_strb, mem_wdata  out  downstream request, same widths as above
- mem_gnt  in  1  downstream accept
- mem_err  in  1  downstream error, cycle after mem_gnt
- mem_rdata  in  DATA_W  downstream read data, cycle after mem_gnt

## Operation
- FSM states: IDLE, HOLD_I, HOLD_D. Reset state is IDLE.
- IDLE:
  - select combinationally among the asserted requests and drive mem_* from the winner in the same cycle (zero added latency);
  - if the winner gets mem_gnt, stay in IDLE;
  - otherwise go to HOLD_I or HOLD_D.
- HOLD_x:
  - mem_* is driven only from requester x; the other requester is ignored;
  - on mem_gnt, return to IDLE.
- Grant routing: imem_gnt = mem_gnt && owner==I; dmem_gnt = mem_gnt && owner==D. Exactly one requester is granted per mem_gnt.
- rsp_owner register:
  - captures the owner on every mem_gnt;
  - rsp_valid register is set for one cycle after each mem_gnt;
  - x_err = mem_err && rsp_valid && rsp_owner==x;
  - the non-owner err is always 0.
- last_grant register (I/D): updated on every mem_gnt; reset value I.
- Back-to-back: a new grant may occur in the same cycle as the previous transaction's response.
- Requester violations (req dropped before gnt in a HOLD state) are undefined; the arbiter keeps mem_req tied to the owner's req.

## Timing
- Request path latency: 0 cycles (combinational req → mem_req, mem_gnt → x_gnt).
- Response latency: 1 cycle after gnt, unchanged by the arbiter.
- While g_resetn is low:
  - mem_req=0, imem_gnt=dmem_gnt=0, imem_err=dmem_err=0;
  - state=IDLE, rsp_valid=0, last_grant=I.
- Reset asserted mid-HOLD: state returns to IDLE at the next edge and any pending response error is dropped.
- mem_err asserted with rsp_valid=0 is ignored (both errs stay 0).

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on contention in IDLE, grant the requester that is not last_grant (alternation under sustained contention).
- Undefined: fixed priority, dmem always wins contention in IDLE; last_grant is still maintained but unused.
- Both modes: a single requester is served immediately.

## Test plan
- Reset, then imem_req=1 at addr 0x1000 with mem_gnt=1 the same cycle → mem_addr=0x1000 and imem_gnt=1 that cycle; mem_rdata=0xDEAD next cycle appears on imem_rdata; imem_err=0.
- dmem write addr 0x2000, strb 0xFF, with mem_gnt low for 3 cycles while imem_req rises in cycle 1 → mem_* stays on dmem for all 4 cycles; dmem_gnt pulses in cycle 4; imem is served in cycle 5.
- Simultaneous imem_req and dmem_req, mem_gnt=1 every cycle, 4 cycles:
  - macro undefined: D,D,D,D;
  - MEM_ARB_ROUND_ROBIN_EN: D,I,D,I.
- dmem granted, mem_err=1 the next cycle → dmem_err=1 and imem_err=0; mem_err=1 with no prior gnt → both errs 0.
- g_resetn pulled low during HOLD_I → next cycle mem_req=0 and state=IDLE; after release, the pending dmem_req wins immediately.
